// File: rtl/xorshift_prng_bank_pkg.sv
// Shared constants, lane state type and datapath helpers for the
// xorshift128+ random bank.
package xorshift_pkg;

  localparam logic [63:0] SPLITMIX_GAMMA = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] SPLITMIX_MUL1  = 64'hBF58476D1CE4E5B9;
  localparam logic [63:0] SPLITMIX_MUL2  = 64'h94D049BB133111EB;

  localparam int XS_A = 23;
  localparam int XS_B = 17;
  localparam int XS_C = 26;

  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
  } lane_state_t;

  typedef enum logic [1:0] {
    SEED,
    WARM,
    RUN
  } prng_fsm_t;

  function automatic logic [63:0] splitmix_mix(
    input logic [63:0] x
  );
    logic [63:0] z;
    z = x;
    z = (z ^ (z >> 30)) * SPLITMIX_MUL1;
    z = (z ^ (z >> 27)) * SPLITMIX_MUL2;
    return z ^ (z >> 31);
  endfunction

  function automatic lane_state_t xs_step(
    input lane_state_t s
  );
    lane_state_t n;
    logic [63:0] a;
    logic [63:0] b;
    a = s.s0;
    b = s.s1;
    a = a ^ (a << XS_A);
    n.s0 = b;
    n.s1 = a ^ b ^ (a >> XS_B) ^ (b >> XS_C);
    return n;
  endfunction

endpackage

// File: rtl/xorshift_prng_bank_lane.sv
// One xorshift128+ generator: word load, step, zero guard.
// Output is the registered s0+s1 sum.
module xorshift128p_lane
  import xorshift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_sel,
  input  logic [63:0] i_word,
  input  logic        i_guard,
  input  logic        i_step,
  output logic [63:0] o_out
);

  lane_state_t r_st;
  lane_state_t w_nxt;

  always_comb begin
    w_nxt = r_st;
    if (i_load) begin
      if (i_sel) w_nxt.s1 = i_word;
      else       w_nxt.s0 = i_word;
    end else if (i_step) begin
      w_nxt = xs_step(r_st);
    end
    // all-zero state would lock the generator at zero forever
    if (i_guard && w_nxt.s0 == '0 && w_nxt.s1 == '0)
      w_nxt.s1 = 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_st <= '0;
    else     r_st <= w_nxt;
  end

  assign o_out = r_st.s0 + r_st.s1;

endmodule

// File: rtl/xorshift_prng_bank.sv
// Multi-lane xorshift128+ bank with splitmix64 seeding and warm-up.
// Optional fire counter: define XORSHIFT_PRNG_BANK_CNT_EN.
module xorshift_prng_bank
  import xorshift_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int SEED_ROUNDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           seed_i,
  input  logic                  reseed_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*LANES-1:0]   out_data,
  output logic                  busy
`ifdef XORSHIFT_PRNG_BANK_CNT_EN
  ,
  output logic [31:0]           gen_count
`endif
);

  localparam int KW = $clog2(2 * LANES);
  localparam int WW = (SEED_ROUNDS > 1) ?
                      $clog2(SEED_ROUNDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(2 * LANES - 1);
  localparam logic [WW-1:0] W_LAST =
    WW'((SEED_ROUNDS > 0) ? SEED_ROUNDS - 1 : 0);

  prng_fsm_t     r_state;
  prng_fsm_t     w_state_n;
  logic [63:0]   r_x;
  logic [63:0]   w_x_n;
  logic [63:0]   w_z;
  logic [KW-1:0] r_k;
  logic [KW-1:0] w_lane;
  logic [WW-1:0] r_w;
  logic          w_load;
  logic          w_step;
  logic          w_guard;
  logic          w_fire;

  assign w_x_n  = r_x + SPLITMIX_GAMMA;
  assign w_z    = splitmix_mix(w_x_n);
  assign w_lane = r_k >> 1;
  assign w_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || reseed_i) r_state <= SEED;
    else                 r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_guard   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      SEED: begin
        w_load = 1'b1;
        if (r_k == K_LAST) begin
          w_guard   = ~reseed_i;
          w_state_n = (SEED_ROUNDS == 0) ? RUN : WARM;
        end
      end
      WARM: begin
        w_step = 1'b1;
        if (r_w == W_LAST) w_state_n = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b0;
        w_step    = out_ready;
      end
      default: w_state_n = SEED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || reseed_i) begin
      r_x <= seed_i;
      r_k <= '0;
      r_w <= '0;
    end else if (r_state == SEED) begin
      r_x <= w_x_n;
      r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
      r_w <= '0;
    end else if (r_state == WARM) begin
      r_w <= r_w + 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    xorshift128p_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load && (w_lane == KW'(g))),
      .i_sel   (r_k[0]),
      .i_word  (w_z),
      .i_guard (w_guard),
      .i_step  (w_step),
      .o_out   (out_data[64*g +: 64])
    );
  end

`ifdef XORSHIFT_PRNG_BANK_CNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || reseed_i)
      r_cnt <= '0;
    else if (w_fire && r_cnt != '1)
      r_cnt <= r_cnt + 32'd1;
  end

  assign gen_count = r_cnt;
`endif

endmodule

// File: tb/tb_xorshift_prng_bank.sv
// Directed bench for xorshift_prng_bank: seeding, timing, stalls,
// reseed and reset restart, plus the optional fire counter.
module tb_xorshift_prng_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  seed_i;
  logic         reseed_i;
  logic         out_ready;
  logic         v, b, v0, b0;
  logic [255:0] d, d0;
`ifdef XORSHIFT_PRNG_BANK_CNT_EN
  logic [31:0]  gc, gc0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]  m_s0 [4];
  logic [63:0]  m_s1 [4];
  logic [255:0] ref_w [200];

  always #5 clk = ~clk;

  xorshift_prng_bank #(.LANES(4), .SEED_ROUNDS(8)) dut (
    .clk(clk), .rst(rst), .seed_i(seed_i),
    .reseed_i(reseed_i), .out_valid(v),
    .out_ready(out_ready), .out_data(d), .busy(b)
`ifdef XORSHIFT_PRNG_BANK_CNT_EN
    , .gen_count(gc)
`endif
  );

  xorshift_prng_bank #(.LANES(4), .SEED_ROUNDS(0)) dut0 (
    .clk(clk), .rst(rst), .seed_i(seed_i),
    .reseed_i(reseed_i), .out_valid(v0),
    .out_ready(out_ready), .out_data(d0), .busy(b0)
`ifdef XORSHIFT_PRNG_BANK_CNT_EN
    , .gen_count(gc0)
`endif
  );

  function automatic logic [63:0] sm(input logic [63:0] x);
    logic [63:0] z;
    z = (x ^ (x >> 30)) * 64'hBF58476D1CE4E5B9;
    z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
    return z ^ (z >> 31);
  endfunction

  task automatic model_step();
    logic [63:0] a, c;
    for (int i = 0; i < 4; i++) begin
      a = m_s0[i];
      c = m_s1[i];
      a = a ^ (a << 23);
      m_s0[i] = c;
      m_s1[i] = a ^ c ^ (a >> 17) ^ (c >> 26);
    end
  endtask

  task automatic model_seed(input logic [63:0] s, input int rounds);
    logic [63:0] x;
    x = s;
    for (int k = 0; k < 8; k++) begin
      x = x + 64'h9E3779B97F4A7C15;
      if (k % 2 == 0) m_s0[k/2] = sm(x);
      else            m_s1[k/2] = sm(x);
    end
    for (int i = 0; i < 4; i++)
      if (m_s0[i] == 0 && m_s1[i] == 0) m_s1[i] = 64'd1;
    for (int r = 0; r < rounds; r++) model_step();
  endtask

  function automatic logic [255:0] model_word();
    logic [255:0] w;
    for (int i = 0; i < 4; i++)
      w[64*i +: 64] = m_s0[i] + m_s1[i];
    return w;
  endfunction

  task automatic do_reset(input logic [63:0] s);
    rst = 1'b1;
    seed_i = s;
    reseed_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // count cycles with busy=1 from now until busy drops
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (b && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; seed_i = '0; reseed_i = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (v !== 1'b0 || v0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b want 0", v, v0);
    end
    n_tests++;
    if (b !== 1'b1 || b0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b want 1", b, b0);
    end
    n_tests++;
    if (d !== '0 || d0 !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", d);
    end
`ifdef XORSHIFT_PRNG_BANK_CNT_EN
    n_tests++;
    if (gc !== 32'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", gc);
    end
`endif
  endtask

  task automatic test_seed0();
    logic [255:0] want;
    out_ready = 1'b0;
    do_reset(64'd0);
    model_seed(64'd0, 0);
    want = model_word();
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 7) begin
        n_tests++;
        if (v0 !== 1'b0) begin
          n_fail++; $display("FAIL seed0_early_valid: got %b want 0", v0);
        end
      end
    end
    n_tests++;
    if (v0 !== 1'b1 || b0 !== 1'b0) begin
      n_fail++;
      $display("FAIL seed0_valid_c9: got v=%b b=%b want 1/0", v0, b0);
    end
    n_tests++;
    if (d0[63:0] !== 64'h509946A41CD733A3) begin
      n_fail++;
      $display("FAIL seed0_lane0: got %h want 509946a41cd733a3", d0[63:0]);
    end
    n_tests++;
    if (d0 !== want) begin
      n_fail++; $display("FAIL seed0_word: got %h want %h", d0, want);
    end
    n_tests++;
    if (b !== 1'b1) begin
      n_fail++; $display("FAIL warm_busy_c9: got %b want 1", b);
    end
    @(posedge clk); #1;
    n_tests++;
    if (d0 !== want || v0 !== 1'b1) begin
      n_fail++; $display("FAIL seed0_hold: got %h want %h", d0, want);
    end
  endtask

  task automatic test_busy();
    int cnt;
    out_ready = 1'b0;
    do_reset(64'h1234);
    count_busy(cnt);
    n_tests++;
    if (cnt != 16 || v !== 1'b1) begin
      n_fail++; $display("FAIL busy_len: got %0d want 16 (v=%b)", cnt, v);
    end
  endtask

  task automatic test_run();
    logic [255:0] want;
    model_seed(64'h1234, 8);
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      want = model_word();
      if (i < 200) ref_w[i] = want;
      n_tests++;
      if (d !== want || v !== 1'b1) begin
        n_fail++;
        $display("FAIL run_word %0d: got %h want %h", i, d, want);
      end
      @(posedge clk); #1;
      model_step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int cnt, acc, cyc;
    logic [255:0] held;
    logic r;
    out_ready = 1'b0;
    do_reset(64'h1234);
    count_busy(cnt);
    acc = 0;
    cyc = 0;
    while (acc < 200 && cyc < 2000) begin
      r = ($urandom_range(0, 99) >= 30);
      out_ready = r;
      held = d;
      @(posedge clk); #1;
      cyc++;
      n_tests++;
      if (r) begin
        if (held !== ref_w[acc]) begin
          n_fail++;
          $display("FAIL stall_word %0d: got %h want %h",
                   acc, held, ref_w[acc]);
        end
        acc++;
      end else if (d !== held || v !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: got %h want %h", d, held);
      end
    end
    n_tests++;
    if (acc != 200) begin
      n_fail++; $display("FAIL stall_budget: got %0d want 200", acc);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reseed();
    int cnt;
    logic [255:0] want;
    out_ready = 1'b0;
    do_reset(64'h1234);
    count_busy(cnt);
    out_ready = 1'b1;
    for (int i = 0; i <= 50; i++) begin
      if (i == 50) begin
        reseed_i = 1'b1;
        seed_i = 64'hFFFF;
        n_tests++;
        if (d !== ref_w[i] || v !== 1'b1) begin
          n_fail++;
          $display("FAIL reseed_w50: got %h want %h", d, ref_w[i]);
        end
      end
      @(posedge clk); #1;
    end
    reseed_i = 1'b0;
    n_tests++;
    if (v !== 1'b0 || b !== 1'b1) begin
      n_fail++;
      $display("FAIL reseed_drop: got v=%b b=%b want 0/1", v, b);
    end
    count_busy(cnt);
    n_tests++;
    if (cnt != 16) begin
      n_fail++; $display("FAIL reseed_busy: got %0d want 16", cnt);
    end
    model_seed(64'hFFFF, 8);
    for (int i = 0; i < 5; i++) begin
      want = model_word();
      n_tests++;
      if (d !== want) begin
        n_fail++;
        $display("FAIL reseed_word %0d: got %h want %h", i, d, want);
      end
      @(posedge clk); #1;
      model_step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_rst_midseed();
    int cnt;
    logic [255:0] want;
    out_ready = 1'b1;
    do_reset(64'hABCD);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(cnt);
    n_tests++;
    if (cnt != 16) begin
      n_fail++; $display("FAIL midrst_busy: got %0d want 16", cnt);
    end
    model_seed(64'hABCD, 8);
    for (int i = 0; i < 5; i++) begin
      want = model_word();
      n_tests++;
      if (d !== want) begin
        n_fail++;
        $display("FAIL midrst_word %0d: got %h want %h", i, d, want);
      end
      @(posedge clk); #1;
      model_step();
    end
    out_ready = 1'b0;
  endtask

`ifdef XORSHIFT_PRNG_BANK_CNT_EN
  task automatic test_count();
    int cnt;
    out_ready = 1'b0;
    do_reset(64'h55);
    count_busy(cnt);
    out_ready = 1'b1;
    repeat (37) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_tests++;
    if (gc !== 32'd37) begin
      n_fail++; $display("FAIL count_37: got %0d want 37", gc);
    end
    @(posedge clk); #1;
    n_tests++;
    if (gc !== 32'd37) begin
      n_fail++; $display("FAIL count_idle: got %0d want 37", gc);
    end
    out_ready = 1'b1;
    reseed_i = 1'b1;
    @(posedge clk); #1;
    reseed_i = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (gc !== 32'd0) begin
      n_fail++; $display("FAIL count_reseed: got %0d want 0", gc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seed0();
    test_busy();
    test_run();
    test_stall();
    test_reseed();
    test_rst_midseed();
`ifdef XORSHIFT_PRNG_BANK_CNT_EN
    test_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
